// File: rtl/xcom_tx_cmd.sv
`default_nettype none
// ============================================================================
// Module   : xcom_tx_cmd
// Brief    : XCOM command-link transmitter. Serializes header + 0/1/2/4 data
//            bytes (+ XOR check byte when XCOM_TX_CHK_EN is defined) onto CH
//            data/toggle-clock link pairs.
// Revision : 1.0
// ============================================================================
module xcom_tx_cmd #(
  parameter int CH = 2
) (
  input  logic          x_clk_i,
  input  logic          x_rst_i,
  input  logic [3:0]    port_id_i,
  input  logic [3:0]    tx_dly_i,
  input  logic          cmd_vld_i,
  output logic          cmd_rdy_o,
  input  logic [3:0]    cmd_op_i,
  input  logic [31:0]   cmd_dt_i,
  input  logic [CH-1:0] cmd_ch_i,
  output logic          tx_done_o,
  output logic [CH-1:0] tx_dt_o,
  output logic [CH-1:0] tx_ck_o,
  output logic [2:0]    tx_st_do
);

`ifdef XCOM_TX_CHK_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_HDR = 3'd1, ST_DATA = 3'd2, ST_CHK = 3'd3, ST_GAP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_HDR = 3'd1, ST_DATA = 3'd2, ST_GAP = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ph_q, ph_d;
  logic [4:0]    bit_q, bit_d;
  logic [39:0]   sh_q, sh_d;
  logic          dt_q, dt_d;
  logic          ck_q, ck_d;
  logic          done_q, done_d;
  logic [CH-1:0] ch_q, ch_d;
  logic [3:0]    p_q, p_d;
  logic [1:0]    lc_q, lc_d;
`ifdef XCOM_TX_CHK_EN
  logic [7:0]    chk_q, chk_d;
`endif

  logic [7:0]    hdr;
  logic [31:0]   data_al;
  logic [4:0]    last_idx;
  logic          half_end;
  logic          to_tail;

  assign hdr      = {cmd_op_i, port_id_i};
  assign half_end = (cnt_q == p_q);

  // Payload left-aligned so the first byte to send sits in [31:24].
  always_comb begin
    data_al = '0;
    case (cmd_op_i[1:0])
      2'd1:    data_al = {cmd_dt_i[7:0], 24'h0};
      2'd2:    data_al = {cmd_dt_i[15:0], 16'h0};
      2'd3:    data_al = cmd_dt_i;
      default: data_al = '0;
    endcase
  end

  always_comb begin
    last_idx = 5'd0;
    case (lc_q)
      2'd1:    last_idx = 5'd7;
      2'd2:    last_idx = 5'd15;
      2'd3:    last_idx = 5'd31;
      default: last_idx = 5'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dt_d    = dt_q;
    ck_d    = ck_q;
    done_d  = 1'b0;
    ch_d    = ch_q;
    p_d     = p_q;
    lc_d    = lc_q;
    to_tail = 1'b0;
`ifdef XCOM_TX_CHK_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_vld_i) begin
          if (cmd_ch_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_HDR;
            ch_d    = cmd_ch_i;
            p_d     = tx_dly_i;
            lc_d    = cmd_op_i[1:0];
            dt_d    = hdr[7];
            sh_d    = {hdr[6:0], data_al, 1'b0};
            cnt_d   = '0;
            ph_d    = 1'b0;
            bit_d   = '0;
`ifdef XCOM_TX_CHK_EN
            chk_d   = hdr ^ data_al[31:24] ^ data_al[23:16] ^ data_al[15:8] ^ data_al[7:0];
`endif
          end
        end
      end
      default: begin
        if (!half_end) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = '0;
          ph_d  = ~ph_q;
          if (!ph_q) begin
            if (state_q != ST_GAP) ck_d = ~ck_q;
          end else begin
            bit_d = bit_q + 5'd1;
            dt_d  = sh_q[39];
            sh_d  = {sh_q[38:0], 1'b0};
            case (state_q)
              ST_HDR: begin
                if (bit_q == 5'd7) begin
                  bit_d = '0;
                  if (lc_q != 2'd0) state_d = ST_DATA;
                  else              to_tail = 1'b1;
                end
              end
              ST_DATA: begin
                if (bit_q == last_idx) begin
                  bit_d   = '0;
                  to_tail = 1'b1;
                end
              end
`ifdef XCOM_TX_CHK_EN
              ST_CHK: begin
                if (bit_q == 5'd7) begin
                  bit_d   = '0;
                  state_d = ST_GAP;
                  dt_d    = 1'b0;
                end
              end
`endif
              ST_GAP: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                dt_d    = 1'b0;
                bit_d   = '0;
              end
              default: begin
                state_d = ST_IDLE;
                dt_d    = 1'b0;
                ck_d    = 1'b0;
              end
            endcase
            if (to_tail) begin
`ifdef XCOM_TX_CHK_EN
              state_d = ST_CHK;
              dt_d    = chk_q[7];
              sh_d    = {chk_q[6:0], 33'd0};
`else
              state_d = ST_GAP;
              dt_d    = 1'b0;
`endif
            end
          end
        end
      end
    endcase
  end

  // Async reset drops every line at once; a frame cut short is left to the
  // receivers' timeout.
  always_ff @(posedge x_clk_i or posedge x_rst_i) begin
    if (x_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
      dt_q    <= 1'b0;
      ck_q    <= 1'b0;
      done_q  <= 1'b0;
      ch_q    <= '0;
      p_q     <= '0;
      lc_q    <= '0;
`ifdef XCOM_TX_CHK_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dt_q    <= dt_d;
      ck_q    <= ck_d;
      done_q  <= done_d;
      ch_q    <= ch_d;
      p_q     <= p_d;
      lc_q    <= lc_d;
`ifdef XCOM_TX_CHK_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign cmd_rdy_o = (state_q == ST_IDLE);
  assign tx_done_o = done_q;
  assign tx_dt_o   = ch_q & {CH{dt_q}};
  assign tx_ck_o   = ch_q & {CH{ck_q}};
  assign tx_st_do  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_xcom_tx_cmd.sv
`default_nettype none
// Bench for xcom_tx_cmd: directed and random commands, every cycle compared
// against a frame-level model built from the bit list and timing arithmetic.
module tb_xcom_tx_cmd;
  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    port_id_i = '0;
  logic [3:0]    tx_dly_i = '0;
  logic          cmd_vld_i = 1'b0;
  logic          cmd_rdy_o;
  logic [3:0]    cmd_op_i = '0;
  logic [31:0]   cmd_dt_i = '0;
  logic [CH-1:0] cmd_ch_i = '0;
  logic          tx_done_o;
  logic [CH-1:0] tx_dt_o;
  logic [CH-1:0] tx_ck_o;
  logic [2:0]    tx_st_do;

  xcom_tx_cmd #(.CH(CH)) dut (
    .x_clk_i  (clk),
    .x_rst_i  (rst),
    .port_id_i(port_id_i),
    .tx_dly_i (tx_dly_i),
    .cmd_vld_i(cmd_vld_i),
    .cmd_rdy_o(cmd_rdy_o),
    .cmd_op_i (cmd_op_i),
    .cmd_dt_i (cmd_dt_i),
    .cmd_ch_i (cmd_ch_i),
    .tx_done_o(tx_done_o),
    .tx_dt_o  (tx_dt_o),
    .tx_ck_o  (tx_ck_o),
    .tx_st_do (tx_st_do)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  bit            m_rdy  = 1'b1;
  bit            m_busy = 1'b0;
  int            m_k, m_n, m_b, m_h;
  bit            m_fb[$];
  logic [CH-1:0] m_mask;
  logic          acc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic build_frame(input logic [3:0] op, input logic [31:0] dt,
                             input logic [3:0] id, input logic [3:0] p);
    logic [7:0] bytes[$];
    logic [7:0] x;
    bytes = {};
    bytes.push_back({op, id});
    case (op[1:0])
      2'd1: bytes.push_back(dt[7:0]);
      2'd2: begin bytes.push_back(dt[15:8]); bytes.push_back(dt[7:0]); end
      2'd3: begin
        bytes.push_back(dt[31:24]); bytes.push_back(dt[23:16]);
        bytes.push_back(dt[15:8]);  bytes.push_back(dt[7:0]);
      end
      default: ;
    endcase
`ifdef XCOM_TX_CHK_EN
    x = 8'h00;
    foreach (bytes[i]) x = x ^ bytes[i];
    bytes.push_back(x);
`else
    x = 8'h00;
`endif
    m_fb.delete();
    foreach (bytes[i])
      for (int j = 7; j >= 0; j--) m_fb.push_back(bytes[i][j]);
    m_b = m_fb.size();
    m_h = int'(p) + 1;
    m_n = (m_b + 1) * 2 * m_h;
  endtask

  task automatic step();
    logic e_rdy, e_done, e_bit, e_ck, zero_mask;
    int   idx, w;
    @(posedge clk);
    acc       = cmd_vld_i && m_rdy;
    zero_mask = (cmd_ch_i == '0);
    if (acc && !zero_mask) begin
      build_frame(cmd_op_i, cmd_dt_i, port_id_i, tx_dly_i);
      m_mask = cmd_ch_i;
      m_busy = 1'b1;
      m_k    = 0;
    end
    #1;
    e_rdy = 1'b1; e_done = 1'b0; e_bit = 1'b0; e_ck = 1'b0;
    if (acc && zero_mask) begin
      e_done = 1'b1;
    end else if (m_busy) begin
      m_k++;
      if (m_k > m_n) begin
        e_done = 1'b1;
        m_busy = 1'b0;
      end else begin
        e_rdy = 1'b0;
        idx = (m_k - 1) / (2 * m_h);
        w   = (m_k - 1) % (2 * m_h);
        if (idx < m_b) begin
          e_bit = m_fb[idx];
          e_ck  = ((idx + ((w >= m_h) ? 1 : 0)) % 2) == 1;
        end
      end
    end
    m_rdy = e_rdy;
    check_eq("rdy",  64'(cmd_rdy_o), 64'(e_rdy));
    check_eq("done", 64'(tx_done_o), 64'(e_done));
    check_eq("dt",   64'(tx_dt_o),   64'({CH{e_bit}} & m_mask));
    check_eq("ck",   64'(tx_ck_o),   64'({CH{e_ck}} & m_mask));
  endtask

  task automatic scramble();
    cmd_vld_i = 1'b0;
    cmd_op_i  = 4'($urandom);
    cmd_dt_i  = $urandom;
    cmd_ch_i  = CH'($urandom);
    tx_dly_i  = 4'($urandom);
    port_id_i = 4'($urandom);
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [31:0] dt, input logic [CH-1:0] ch,
                         input logic [3:0] p, input logic [3:0] id);
    int t;
    cmd_op_i = op; cmd_dt_i = dt; cmd_ch_i = ch; tx_dly_i = p; port_id_i = id;
    cmd_vld_i = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 4000) begin step(); t++; end
    check_eq("accept", 64'(acc), 64'd1);
    scramble();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (m_busy && t < 4000) begin step(); t++; end
    check_eq("drain", 64'(m_busy), 64'd0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_dt",   64'(tx_dt_o),   64'd0);
    check_eq("rst_ck",   64'(tx_ck_o),   64'd0);
    check_eq("rst_done", 64'(tx_done_o), 64'd0);
    check_eq("rst_rdy",  64'(cmd_rdy_o), 64'd1);
    m_busy = 1'b0;
    m_rdy  = 1'b1;
    cmd_vld_i = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    int t;
    #1;
    check_eq("init_rdy",  64'(cmd_rdy_o), 64'd1);
    check_eq("init_done", 64'(tx_done_o), 64'd0);
    check_eq("init_dt",   64'(tx_dt_o),   64'd0);
    check_eq("init_ck",   64'(tx_ck_o),   64'd0);
    #20 rst = 1'b0;
    repeat (20) step();

    run_cmd(4'h1, 32'h0000_005C, 2'b11, 4'd0, 4'hA);
    drain();
    step();
    run_cmd(4'h3, 32'hDEAD_BEEF, 2'b01, 4'd3, 4'h5);
    drain();
    run_cmd(4'h0, $urandom, 2'b10, 4'd1, 4'h7);
    drain();
    step();
    // Mask 0: accepted with an immediate done pulse, then back-to-back pair.
    run_cmd(4'h2, $urandom, 2'b00, 4'd2, 4'h3);
    run_cmd(4'h2, 32'h0000_A55A, 2'b11, 4'd2, 4'h9);
    run_cmd(4'h1, 32'h0000_0081, 2'b10, 4'd0, 4'h1);
    drain();
    run_cmd(4'hE, 32'h0000_1234, 2'b11, 4'd15, 4'hF);
    drain();

    // Reset while DATA bit 5 is on the wire.
    run_cmd(4'h3, $urandom, 2'b11, 4'd1, 4'h6);
    t = 0;
    while (m_busy && ((m_k - 1) / (2 * m_h)) < 13 && t < 4000) begin step(); t++; end
    do_reset();
    repeat (3) step();
    run_cmd(4'h2, 32'h0000_C3E1, 2'b11, 4'd1, 4'h2);
    drain();

    for (int i = 0; i < 25; i++) begin
      run_cmd(4'($urandom), $urandom, CH'($urandom), 4'($urandom_range(0, 3)), 4'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        drain();
        repeat ($urandom_range(0, 4)) step();
      end
    end
    drain();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xcom_tx_cmd.md
Name: xcom_tx_cmd

Overview:
Transmit side of the XCOM command link. Accepts one command (op, data, channel mask) from core logic, serializes it as a header byte plus 0/1/2/4 data bytes, and drives it onto CH two-wire links (data + toggle clock). This is the counterpart of the XCOM receive path: its frames are exactly what the per-channel link receivers decode into op/data/source-id. Single clock domain; the core-side handshake is valid/ready.

Parameters:
CH, 2, number of outgoing links (1..8)

Ports:
x_clk_i  in  1  link clock
x_rst_i  in  1  asynchronous reset, active-high
port_id_i  in  4  own port id, sent in header low nibble
tx_dly_i  in  4  bit-phase length P; each half-bit lasts P+1 cycles
cmd_vld_i  in  1  command valid
cmd_rdy_o  out  1  block ready to accept
cmd_op_i  in  4  opcode; op[1:0] = length code
cmd_dt_i  in  32  payload
cmd_ch_i  in  CH  destination link mask
tx_done_o  out  1  one-cycle pulse when a frame (including gap) completes
tx_dt_o  out  CH  serial data per link
tx_ck_o  out  CH  serial toggle clock per link
tx_st_do  out  3  debug: FSM state encoding

Behaviour:
- Reset (async, active-high): FSM=IDLE, cmd_rdy_o=1, tx_done_o=0, tx_dt_o=0, tx_ck_o=0, all counters 0.
- Accept: when cmd_vld_i & cmd_rdy_o are high on a rising edge, latch op, dt, ch mask, port_id_i and tx_dly_i. cmd_rdy_o is 0 from the next cycle. Later changes to the inputs do not affect the frame in flight.
- Length code op[1:0]: 0 -> 0 data bytes, 1 -> dt[7:0], 2 -> dt[15:0], 3 -> dt[31:0].
- Header byte = {op[3:0], port_id[3:0]}. All bytes are sent MSB first, header first. Total bits B = 8 + 8*nbytes.
- Bit timing: phase A (P+1 cycles) drives tx_dt with the new bit and holds ck. Phase B (P+1 cycles) holds dt and toggles ck once at the start of B. One bit takes 2(P+1) cycles. B is always even, so ck returns to 0 at frame end.
- FSM: IDLE -> HDR (8 bits) -> DATA (8*nbytes bits; skipped if 0) -> [CHK] -> GAP -> IDLE.
  - GAP: dt=0, ck held, for 2(P+1) cycles.
  - On GAP exit: tx_done_o pulses for 1 cycle and cmd_rdy_o returns to 1 in the same cycle.
- Latency: accept at edge 0. First header bit appears on tx_dt_o at cycle 1. Frame occupies cycles 1..B*2(P+1), then GAP. cmd_rdy_o and tx_done_o are high at cycle B*2(P+1)+2(P+1)+1.
- Masking: links with cmd_ch_i bit = 0 keep dt=0 and ck=0 for the whole frame. Unmasked links carry identical waveforms.
- Mask = 0: command is accepted, no frame is sent, FSM goes straight to GAP-exit. tx_done_o pulses at cycle 1 and cmd_rdy_o is 1 at cycle 1.
- Back-to-back: cmd_vld_i held high is accepted in the same cycle cmd_rdy_o rises. No extra idle cycle beyond GAP.
- Reset mid-frame: all lines drop to 0 immediately and the frame is abandoned. Receivers discard it via their own timeout.
- P=15 (max): half-bit = 16 cycles. Counters are sized to P+1 without overflow.

Optional Feature:
Macro XCOM_TX_CHK_EN.
- Defined: after the last data byte, state CHK sends one extra byte = XOR of the header and all data bytes. B increases by 8 and ck parity stays even.
- Not defined: CHK state is absent and the frame ends after the data. tx_st_do never shows the CHK code.

Test Plan:
- Reset, then idle for 20 cycles -> cmd_rdy_o=1, tx_dt_o=0, tx_ck_o=0, tx_done_o=0 throughout.
- P=0, port_id=4'hA, op=4'h1, dt=0x5C, mask=2'b11 -> both links carry bits 0x1A then 0x5C; ck toggles 16 times and ends at 0; tx_done_o and cmd_rdy_o high at cycle 35 (with CHK_EN: extra byte 0x46, cycle 51).
- P=3, op=4'h3, dt=0xDEADBEEF, mask=2'b01 -> link0 sends 40 bits (header, then DE AD BE EF), each half-bit 4 cycles, done at cycle 329; link1 stays 0 throughout.
- op=4'h0, P=1, mask=2'b10 -> header-only frame of 8 bits; rdy returns at cycle 37.
- cmd_vld_i held high with two commands queued by the bench, and tx_dly_i changed mid-frame -> second command accepted on the cycle rdy rises; first frame's timing unchanged.
- Assert x_rst_i during DATA bit 5 -> tx_dt_o/tx_ck_o go to 0 asynchronously; after release, rdy=1 and the next command transmits correctly.
